// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the load/store path: word type, LSU states, funct3 codes
// and the latched request record.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, FAULT} mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic       wr;
    logic [2:0] f3;
    logic [1:0] lane;
  } mem_req_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic m;
    m = 1'b0;
    if (f3 == F3_H || f3 == F3_HU) m = lane[0];
    else if (f3 == F3_W)           m = (lane != 2'b00);
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: places store data and byte enables on the bus lanes,
// and pulls a byte/half/word out of read data with sign or zero extension.
module mem_lane_align
  import cpu_types_pkg::*;
(
  input  logic [1:0] st_lane_i,
  input  logic [2:0] st_f3_i,
  input  word_t      st_data_i,
  output logic [3:0] be_o,
  output word_t      wdata_o,
  input  logic [1:0] ld_lane_i,
  input  logic [2:0] ld_f3_i,
  input  word_t      ld_rdata_i,
  output word_t      ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = st_data_i;
    unique case (st_f3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << st_lane_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      F3_H, F3_HU: begin
        be_o    = 4'b0011 << st_lane_i;
        wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    unique case (ld_lane_i)
      2'd0:    ld_byte = ld_rdata_i[7:0];
      2'd1:    ld_byte = ld_rdata_i[15:8];
      2'd2:    ld_byte = ld_rdata_i[23:16];
      default: ld_byte = ld_rdata_i[31:24];
    endcase
  end

  // Halfwords are aligned, so only lane[1] picks the half.
  assign ld_half = ld_lane_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

  always_comb begin
    unique case (ld_f3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data_o = {24'd0, ld_byte};
      F3_HU:   ld_data_o = {16'd0, ld_half};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one word-aligned request/ack bus transaction per memory op,
// stalling the core until it completes, faults or times out.
module mem_access_unit
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [2:0]        funct3,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_be,
  output logic              bus_ren,
  output logic              bus_wen,
  output logic [DATA_W-1:0] load_data,
  output logic              stall,
  output logic              done,
  output logic              misaligned,
  output logic              access_fault
);

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic             TO_EN    = (TIMEOUT > 0);

  mem_state_t        state_q, state_d;
  mem_req_t          req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, load_q;
  logic [3:0]        be_q;
  logic              ren_q, ren_d, wen_q, wen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic  req_v, in_idle, bad_req, mis, go;
  logic  [3:0] st_be;
  word_t st_wdata, ld_ext;

  mem_lane_align u_align (
    .st_lane_i  (alu_result[1:0]),
    .st_f3_i    (funct3),
    .st_data_i  (store_data),
    .be_o       (st_be),
    .wdata_o    (st_wdata),
    .ld_lane_i  (req_q.lane),
    .ld_f3_i    (req_q.f3),
    .ld_rdata_i (bus_rdata),
    .ld_data_o  (ld_ext)
  );

  // Request classification is only live in IDLE and is masked while in reset.
  assign req_v   = mem_read | mem_write;
  assign in_idle = nRst && (state_q == IDLE);
  assign bad_req = (mem_read & mem_write) | ~f3_legal(funct3);
  assign mis     = f3_misaligned(funct3, alu_result[1:0]);
  assign go      = in_idle & req_v & ~bad_req & ~mis;

  assign stall        = go | (state_q == BUSY);
  assign done         = (state_q == DONE);
  assign misaligned   = in_idle & req_v & ~bad_req & mis;
  assign access_fault = (in_idle & req_v & bad_req) | (state_q == FAULT);

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign bus_ren   = ren_q;
  assign bus_wen   = wen_q;
  assign load_data = load_q;

  always_comb begin
    state_d = state_q;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (go) begin
        state_d = BUSY;
        ren_d   = mem_read;
        wen_d   = mem_write;
        cnt_d   = '0;
      end
      BUSY: begin
        ren_d = ren_q;
        wen_d = wen_q;
        if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
        if (bus_ack) begin
          state_d = DONE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          state_d = FAULT;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
        end
      end
      DONE, FAULT: state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      cnt_q   <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      cnt_q   <= cnt_d;
      if (go) begin
        req_q   <= '{wr: mem_write, f3: funct3, lane: alu_result[1:0]};
        addr_q  <= {alu_result[ADDR_W-1:2], 2'b00};
        wdata_q <= st_wdata;
        be_q    <= st_be;
      end
      // Stores leave the previous load result untouched.
      if ((state_q == BUSY) && bus_ack && !req_q.wr) load_q <= ld_ext;
    end
  end

endmodule
